board_mem_arbiter: RTL

- Sequences and shares the single-port game-board tile RAM (1024 x 4-bit, address = {y[4:0], x[4:0]}) between three requesters: display scanner, Pac-Man move logic and ghost logic.
- Performs an atomic read-modify-write "eat" on behalf of Pac-Man and reports eaten pellets to the score logic.
- Sits between Game_Top's movement/display blocks and the board RAM.

---
 rtl/board_mem_arbiter_if.sv | 64 ++++++
 rtl/board_mem_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter_if.sv
// Board RAM arbiter bus: requester handshakes, RAM port and score outputs.
// Slave side is the arbiter; master side is the game logic / RAM.
interface board_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
);
    logic              run;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_grant;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_rdata;

    logic              pac_req;
    logic              pac_eat;
    logic [4:0]        pac_x;
    logic [4:0]        pac_y;
    logic              pac_grant;
    logic              pac_valid;
    logic [DATA_W-1:0] pac_rdata;

    logic              ghost_req;
    logic [4:0]        ghost_x;
    logic [4:0]        ghost_y;
    logic              ghost_grant;
    logic              ghost_valid;
    logic [DATA_W-1:0] ghost_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              pellet_eaten;
    logic              power_eaten;
    logic [9:0]        dots_eaten;

    modport slave (
        input  run,
        input  disp_req, disp_addr,
        output disp_grant, disp_valid, disp_rdata,
        input  pac_req, pac_eat, pac_x, pac_y,
        output pac_grant, pac_valid, pac_rdata,
        input  ghost_req, ghost_x, ghost_y,
        output ghost_grant, ghost_valid, ghost_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output pellet_eaten, power_eaten, dots_eaten
    );

    modport master (
        output run,
        output disp_req, disp_addr,
        input  disp_grant, disp_valid, disp_rdata,
        output pac_req, pac_eat, pac_x, pac_y,
        input  pac_grant, pac_valid, pac_rdata,
        output ghost_req, ghost_x, ghost_y,
        input  ghost_grant, ghost_valid, ghost_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  pellet_eaten, power_eaten, dots_eaten
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// Shares the single-port board tile RAM between display, Pac-Man and ghost,
// and performs Pac-Man's atomic eat (read, then clear pellet) with scoring.
module board_mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic clock,
    input  logic reset,
    board_mem_arbiter_if.slave bus
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_EAT_CHK = 1'b1;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]     W_MAX    = CW'(MAX_WAIT);
    localparam logic [DATA_W-1:0] T_PELLET = DATA_W'(1);
    localparam logic [DATA_W-1:0] T_POWER  = DATA_W'(2);
    localparam logic [9:0]        DOTS_MAX = 10'd1023;

    logic [0:0]        r_state;
    logic [CW-1:0]     r_pac_wait;
    logic [CW-1:0]     r_ghost_wait;
    logic              r_rr_ghost;
    logic [ADDR_W-1:0] r_eat_addr;
    logic              r_disp_v;
    logic              r_pac_v;
    logic              r_ghost_v;
    logic              r_pellet;
    logic              r_power;
    logic [9:0]        r_dots;

    logic [ADDR_W-1:0] w_pac_addr;
    logic [ADDR_W-1:0] w_ghost_addr;
    logic              w_issue;
    logic              w_pac_old;
    logic              w_ghost_old;
    logic              w_gd;
    logic              w_gp;
    logic              w_gg;
    logic              w_eat_chk;
    logic              w_hit_pellet;
    logic              w_hit_power;
    logic              w_hit;

    assign w_pac_addr   = ADDR_W'({bus.pac_y, bus.pac_x});
    assign w_ghost_addr = ADDR_W'({bus.ghost_y, bus.ghost_x});

    assign w_issue     = (r_state == S_IDLE) && bus.run && !reset;
    assign w_pac_old   = bus.pac_req && (r_pac_wait >= W_MAX);
    assign w_ghost_old = bus.ghost_req && (r_ghost_wait >= W_MAX);

    // Starved pac/ghost beat display; otherwise display beats round-robin.
    always_comb begin
        w_gd = 1'b0;
        w_gp = 1'b0;
        w_gg = 1'b0;
        if (w_issue) begin
            priority case (1'b1)
                w_pac_old:    w_gp = 1'b1;
                w_ghost_old:  w_gg = 1'b1;
                bus.disp_req: w_gd = 1'b1;
                bus.pac_req && (!bus.ghost_req || !r_rr_ghost):
                              w_gp = 1'b1;
                bus.ghost_req: w_gg = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_eat_chk    = (r_state == S_EAT_CHK);
    assign w_hit_pellet = w_eat_chk && (bus.mem_rdata == T_PELLET);
    assign w_hit_power  = w_eat_chk && (bus.mem_rdata == T_POWER);
    assign w_hit        = w_hit_pellet || w_hit_power;

    always_comb begin
        bus.mem_addr = '0;
        if (w_eat_chk)
            bus.mem_addr = r_eat_addr;
        else if (w_gd)
            bus.mem_addr = bus.disp_addr;
        else if (w_gp)
            bus.mem_addr = w_pac_addr;
        else if (w_gg)
            bus.mem_addr = w_ghost_addr;
    end

    assign bus.mem_we    = w_hit;
    assign bus.mem_wdata = '0;

    assign bus.disp_grant  = w_gd;
    assign bus.pac_grant   = w_gp;
    assign bus.ghost_grant = w_gg;

    // RAM data arrives one cycle after issue; steer it to the owner.
    assign bus.disp_valid  = r_disp_v;
    assign bus.pac_valid   = r_pac_v;
    assign bus.ghost_valid = r_ghost_v;
    assign bus.disp_rdata  = r_disp_v  ? bus.mem_rdata : '0;
    assign bus.pac_rdata   = r_pac_v   ? bus.mem_rdata : '0;
    assign bus.ghost_rdata = r_ghost_v ? bus.mem_rdata : '0;

    assign bus.pellet_eaten = r_pellet;
    assign bus.power_eaten  = r_power;
    assign bus.dots_eaten   = r_dots;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_eat_addr <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_gp) begin
                        r_eat_addr <= w_pac_addr;
                        if (bus.pac_eat)
                            r_state <= S_EAT_CHK;
                    end
                end
                S_EAT_CHK: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pac_wait   <= '0;
            r_ghost_wait <= '0;
            r_rr_ghost   <= 1'b0;
        end else begin
            if (!bus.pac_req || w_gp)
                r_pac_wait <= '0;
            else if (bus.run && (r_pac_wait < W_MAX))
                r_pac_wait <= r_pac_wait + 1'b1;

            if (!bus.ghost_req || w_gg)
                r_ghost_wait <= '0;
            else if (bus.run && (r_ghost_wait < W_MAX))
                r_ghost_wait <= r_ghost_wait + 1'b1;

            if (w_gp || w_gg)
                r_rr_ghost <= ~r_rr_ghost;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp_v  <= 1'b0;
            r_pac_v   <= 1'b0;
            r_ghost_v <= 1'b0;
            r_pellet  <= 1'b0;
            r_power   <= 1'b0;
            r_dots    <= '0;
        end else begin
            r_disp_v  <= w_gd;
            r_pac_v   <= w_gp;
            r_ghost_v <= w_gg;
            r_pellet  <= w_hit_pellet;
            r_power   <= w_hit_power;
            if (w_hit && (r_dots != DOTS_MAX))
                r_dots <= r_dots + 10'd1;
        end
    end

endmodule
